munoc_switch_allocator: RTL and testbench
=========================================

# munoc_switch_allocator

Per-output round-robin switch allocator for a MUNOC router. It takes the one-hot `routing_info` vector that each input port's routing-table lookup produces, arbitrates every output port among the inputs requesting it, and locks each granted output to its owner until the packet's tail flit transfers. It drives the crossbar select indices and the valid/ready handshakes between router input buffers and output links.

## Interface
Parameters:
- `NUM_INPUT`, 4: number of router input ports, at least 2.
- `NUM_OUTPUT`, 4: number of router output ports. Equals the routing-table `NUM_OUTPUT`.
- `BW_INPUT_INDEX`, 2: width of an input index. Must be at least clog2(`NUM_INPUT`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstnn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  NUM_INPUT  flit present at input i.
- `in_route`  in  NUM_INPUT*NUM_OUTPUT  routing_info of input i at bits [i*NUM_OUTPUT +: NUM_OUTPUT]. One-hot; upstream holds it stable for every flit of a packet.
- `in_last`  in  NUM_INPUT  flit at input i is the packet tail.
- `in_ready`  out  NUM_INPUT  flit at input i is consumed this cycle.
- `out_valid`  out  NUM_OUTPUT  flit present on output o.
- `out_ready`  in  NUM_OUTPUT  downstream accepts output o.
- `out_last`  out  NUM_OUTPUT  tail flag forwarded on output o.
- `out_sel`  out  NUM_OUTPUT*BW_INPUT_INDEX  owner index of output o at bits [o*BW_INPUT_INDEX +: BW_INPUT_INDEX], used as the crossbar mux select.
- `route_error`  out  1  sticky flag: a non-one-hot route was seen.

## Operation
- Request: input i requests output o when `in_valid[i]` is 1, `in_route` for i is exactly one-hot, and bit o of that route is set.
- Each output runs an independent two-state FSM with states IDLE and LOCKED. Per-output registers:
  - `owner` (BW_INPUT_INDEX bits)
  - `ptr` (BW_INPUT_INDEX bits), the round-robin priority start
- IDLE:
  - `out_valid[o]` is 0.
  - If any input requests o, pick the first requester scanning ptr, ptr+1, … modulo NUM_INPUT.
  - Register that input as `owner` and go to LOCKED next cycle.
  - No flit transfers in IDLE.
- LOCKED:
  - `out_valid[o]` = `in_valid[owner]`.
  - `out_last[o]` = `in_last[owner]`.
  - `in_ready[owner]` = `out_ready[o]`.
  - A transfer occurs when `out_valid[o]` and `out_ready[o]` are both 1.
  - On a transfer with `out_last[o]` = 1: go to IDLE, and set ptr = owner+1, wrapping NUM_INPUT-1 to 0.
  - Changes to `in_route` while LOCKED are ignored.
  - `in_valid[owner]` dropping to 0 mid-packet keeps the lock with `out_valid` low.
- `out_sel[o]` always equals `owner`. Its value is don't-care in IDLE but is driven as the registered owner.
- `in_ready[i]` is 0 unless i owns a LOCKED output or i is in error drain.
- An input requests only one output, so no input is ever granted twice.
- Error drain:
  - Condition: `in_valid[i]` = 1 and `in_route` for i is zero or multi-hot.
  - Response: `in_ready[i]` = 1 (flit discarded), i is not a requester for any output, and `route_error` is set.
  - `route_error` clears only on reset.
- Reset values (all asserted asynchronously while `rstnn` = 0):
  - every FSM in IDLE, owner = 0, ptr = 0
  - `out_valid` = 0, `out_last` = 0, `in_ready` = 0, `out_sel` = 0, `route_error` = 0
- Reset mid-packet: the lock is dropped. Upstream and downstream are reset together.

## Timing
- Arbitration latency: a head flit requesting an idle output at cycle t is granted at the t edge. The earliest transfer is cycle t+1.
- Throughput while LOCKED: 1 flit/cycle with `out_ready` held 1. A packet of N flits with no stalls occupies cycles t+1..t+N.
- Back-to-back packets on one output incur exactly one IDLE bubble cycle after each tail.
- Outputs arbitrate in parallel. Different outputs can grant in the same cycle.
- `out_valid`, `out_last` and `in_ready` are combinational from registered state plus `in_valid`, `in_last` and `out_ready`. There is no combinational path from `in_route` to them, except in error drain.
- Tail transfer and a new request at the same cycle: the new request is arbitrated in the following IDLE cycle using the updated ptr.

## Test plan
- Single packet: input 1 sends 3 flits to output 2 (`in_route`=4'b0100), `out_ready`=1, head at cycle 0. Required: `out_sel[2]`=1; transfers at cycles 1, 2, 3; `out_last[2]`=1 at cycle 3; output 2 IDLE at cycle 4.
- Round-robin fairness: inputs 0, 1 and 3 continuously send 1-flit packets to output 0. Required grant order 0, 1, 3, 0, 1, 3…, one grant every 2 cycles.
- Backpressure and lock: input 2 holds a 4-flit packet to output 1 with `out_ready[1]` toggling 1,0,1,0…. Meanwhile input 0 requests output 1. Required: output 1 stays owned by 2 until the tail, and input 0 is granted only in the IDLE cycle after the tail.
- Parallel outputs: input 0 targets output 3 and input 3 targets output 0 in the same cycle. Required: both granted at cycle 1, and both `in_ready` equal 1 simultaneously.
- Route error: input 1 presents `in_route`=4'b0000, then 4'b0110. Required: `in_ready[1]`=1 on both, no `out_valid` asserted, `route_error` 1 from the next edge and held until reset.
- Reset mid-packet: assert `rstnn`=0 during flit 2 of a 4-flit packet. Required: `out_valid` and `in_ready` are 0 immediately, all outputs IDLE, ptr 0. A new request after release follows the normal one-cycle latency.

Source files
------------

// File: rtl/munoc_switch_allocator.sv
// munoc_switch_allocator
//   Per-output round-robin switch allocator for a MUNOC router. Each output
//   port runs an IDLE/LOCKED FSM. In IDLE it grants the first requesting input
//   found scanning from its round-robin pointer. In LOCKED it stays with that
//   owner until the tail flit transfers. Inputs whose valid flit carries a
//   zero or multi-hot route are drained (flit discarded), and a sticky error
//   flag is raised.
//
// Ports
//   clk          rising-edge clock
//   rstnn        asynchronous active-low reset
//   in_valid     [NUM_INPUT]               flit present at input i
//   in_route     [NUM_INPUT*NUM_OUTPUT]    one-hot route of input i
//   in_last      [NUM_INPUT]               tail flag of input i
//   in_ready     [NUM_INPUT]               flit at input i consumed this cycle
//   out_valid    [NUM_OUTPUT]              flit present on output o
//   out_ready    [NUM_OUTPUT]              downstream accepts output o
//   out_last     [NUM_OUTPUT]              tail flag forwarded on output o
//   out_sel      [NUM_OUTPUT*BW_INPUT_INDEX] crossbar select (owner of o)
//   route_error  sticky: a non-one-hot route was seen
module munoc_switch_allocator #(
  parameter int NUM_INPUT      = 4,
  parameter int NUM_OUTPUT     = 4,
  parameter int BW_INPUT_INDEX = 2
) (
  input  logic                                 clk,
  input  logic                                 rstnn,
  input  logic [NUM_INPUT-1:0]                 in_valid,
  input  logic [NUM_INPUT*NUM_OUTPUT-1:0]      in_route,
  input  logic [NUM_INPUT-1:0]                 in_last,
  output logic [NUM_INPUT-1:0]                 in_ready,
  output logic [NUM_OUTPUT-1:0]                out_valid,
  input  logic [NUM_OUTPUT-1:0]                out_ready,
  output logic [NUM_OUTPUT-1:0]                out_last,
  output logic [NUM_OUTPUT*BW_INPUT_INDEX-1:0] out_sel,
  output logic                                 route_error
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                    state_q [NUM_OUTPUT];
  state_e                    state_d [NUM_OUTPUT];
  logic [BW_INPUT_INDEX-1:0] owner_q [NUM_OUTPUT];
  logic [BW_INPUT_INDEX-1:0] owner_d [NUM_OUTPUT];
  logic [BW_INPUT_INDEX-1:0] ptr_q   [NUM_OUTPUT];
  logic [BW_INPUT_INDEX-1:0] ptr_d   [NUM_OUTPUT];
  logic                      route_error_q;
  logic                      route_error_d;

  logic [NUM_INPUT-1:0]                 onehot;
  logic [NUM_INPUT-1:0]                 busy;
  logic [NUM_INPUT-1:0]                 drain;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] req;
  logic [NUM_OUTPUT-1:0]                xfer;

  // Route decode. An input that already owns a locked output is neither a
  // requester nor drained: its route is ignored for the rest of the packet.
  always_comb begin
    logic [NUM_OUTPUT-1:0] r;
    onehot = '0;
    busy   = '0;
    drain  = '0;
    req    = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      r         = in_route[i*NUM_OUTPUT +: NUM_OUTPUT];
      onehot[i] = (r != '0) && ((r & (r - 1'b1)) == '0);
      for (int o = 0; o < NUM_OUTPUT; o++) begin
        if (state_q[o] == ST_LOCKED && owner_q[o] == BW_INPUT_INDEX'(i))
          busy[i] = 1'b1;
      end
      drain[i] = in_valid[i] & ~onehot[i] & ~busy[i];
      for (int o = 0; o < NUM_OUTPUT; o++)
        req[o][i] = in_valid[i] & onehot[i] & ~busy[i] & r[o];
    end
  end

  // Handshake muxing: only registered state selects, so in_route reaches
  // these outputs solely through the drain term.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    in_ready  = drain;
    xfer      = '0;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        for (int i = 0; i < NUM_INPUT; i++) begin
          if (owner_q[o] == BW_INPUT_INDEX'(i)) begin
            out_valid[o] = in_valid[i];
            out_last[o]  = in_last[i];
            in_ready[i]  = in_ready[i] | out_ready[o];
          end
        end
      end
      xfer[o] = out_valid[o] & out_ready[o];
    end
  end

  always_comb begin
    out_sel = '0;
    for (int o = 0; o < NUM_OUTPUT; o++)
      out_sel[o*BW_INPUT_INDEX +: BW_INPUT_INDEX] = owner_q[o];
  end

  assign route_error = route_error_q;

  // Next-state: round-robin grant in IDLE, release on tail transfer.
  always_comb begin
    logic found;
    route_error_d = route_error_q | (|drain);
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      case (state_q[o])
        ST_IDLE: begin
          // Scan ptr, ptr+1, ... (mod NUM_INPUT); first requester wins.
          for (int k = 0; k < NUM_INPUT; k++) begin
            for (int i = 0; i < NUM_INPUT; i++) begin
              if (!found && req[o][i] &&
                  i == (int'(ptr_q[o]) + k) % NUM_INPUT) begin
                found      = 1'b1;
                owner_d[o] = BW_INPUT_INDEX'(i);
              end
            end
          end
          if (found) state_d[o] = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (xfer[o] && out_last[o]) begin
            state_d[o] = ST_IDLE;
            ptr_d[o]   = (owner_q[o] == BW_INPUT_INDEX'(NUM_INPUT - 1)) ?
                         '0 : owner_q[o] + 1'b1;
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int o = 0; o < NUM_OUTPUT; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      route_error_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_OUTPUT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      route_error_q <= route_error_d;
    end
  end

endmodule

// File: tb/tb_munoc_switch_allocator.sv
// Directed bench for munoc_switch_allocator (4 inputs, 4 outputs).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
module tb_munoc_switch_allocator;

  logic        clk;
  logic        rstnn;
  logic [3:0]  in_valid;
  logic [15:0] in_route;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  out_last;
  logic [7:0]  out_sel;
  logic        route_error;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  munoc_switch_allocator #(
    .NUM_INPUT      (4),
    .NUM_OUTPUT     (4),
    .BW_INPUT_INDEX (2)
  ) dut (
    .clk         (clk),
    .rstnn       (rstnn),
    .in_valid    (in_valid),
    .in_route    (in_route),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_sel     (out_sel),
    .route_error (route_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] sel(input int o);
    return 32'(out_sel[o*2 +: 2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_route(input int i, input logic [3:0] r);
    in_route[i*4 +: 4] = r;
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_route  = '0;
    in_last   = '0;
    out_ready = 4'hF;
  endtask

  initial begin
    rstnn = 1'b0;
    clear_inputs();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_route_error", 32'(route_error), 0);
    tick();
    tick();
    rstnn = 1'b1;

    // Single packet: input 1, 3 flits to output 2, head at cycle 0.
    in_valid[1] = 1'b1;
    set_route(1, 4'b0100);
    @(negedge clk);
    chk("sp_c0_valid", 32'(out_valid), 0);
    chk("sp_c0_ready", 32'(in_ready), 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      in_last[1] = (c == 3);
      @(negedge clk);
      chk("sp_sel", sel(2), 1);
      chk("sp_valid", 32'(out_valid), 32'h4);
      chk("sp_ready", 32'(in_ready), 32'h2);
      chk("sp_last", 32'(out_last[2]), (c == 3) ? 1 : 0);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk("sp_c4_idle", 32'(out_valid), 0);
    tick();

    // Round robin: inputs 0, 1, 3 send single-flit packets to output 0.
    in_valid = 4'b1011;
    in_last  = 4'b1011;
    set_route(0, 4'b0001);
    set_route(1, 4'b0001);
    set_route(3, 4'b0001);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        chk("rr_valid", 32'(out_valid[0]), 1);
        chk("rr_sel", sel(0), 32'(rr_exp[c/2]));
      end else begin
        chk("rr_bubble", 32'(out_valid[0]), 0);
      end
      tick();
    end
    clear_inputs();
    tick();

    // Backpressure and lock: input 2 sends 4 flits to output 1 while
    // out_ready[1] toggles; input 0 competes from cycle 1.
    in_valid[2] = 1'b1;
    set_route(2, 4'b0010);
    @(negedge clk);
    chk("bp_c0_valid", 32'(out_valid), 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      in_valid[0]  = 1'b1;
      in_last[0]   = 1'b1;
      set_route(0, 4'b0010);
      out_ready[1] = (k % 2 == 1);
      in_last[2]   = (k == 7);
      @(negedge clk);
      chk("bp_sel", sel(1), 2);
      chk("bp_valid", 32'(out_valid), 32'h2);
      chk("bp_ready", 32'(in_ready), (k % 2 == 1) ? 32'h4 : 32'h0);
      chk("bp_last", 32'(out_last[1]), (k == 7) ? 1 : 0);
    end
    tick();
    in_valid[2]  = 1'b0;
    in_last[2]   = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_bubble_valid", 32'(out_valid), 0);
    chk("bp_bubble_ready", 32'(in_ready), 0);
    tick();
    @(negedge clk);
    chk("bp_next_sel", sel(1), 0);
    chk("bp_next_ready", 32'(in_ready), 32'h1);
    chk("bp_next_last", 32'(out_last[1]), 1);
    tick();
    clear_inputs();
    tick();

    // Parallel outputs: input 0 -> output 3, input 3 -> output 0.
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    set_route(0, 4'b1000);
    set_route(3, 4'b0001);
    @(negedge clk);
    chk("par_c0_ready", 32'(in_ready), 0);
    tick();
    @(negedge clk);
    chk("par_ready", 32'(in_ready), 32'h9);
    chk("par_valid", 32'(out_valid), 32'h9);
    chk("par_sel3", sel(3), 0);
    chk("par_sel0", sel(0), 3);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("par_idle", 32'(out_valid), 0);
    tick();

    // Route error: zero route then multi-hot route on input 1.
    in_valid[1] = 1'b1;
    set_route(1, 4'b0000);
    @(negedge clk);
    chk("err0_ready", 32'(in_ready), 32'h2);
    chk("err0_valid", 32'(out_valid), 0);
    chk("err0_flag_before", 32'(route_error), 0);
    tick();
    set_route(1, 4'b0110);
    @(negedge clk);
    chk("err1_ready", 32'(in_ready), 32'h2);
    chk("err1_valid", 32'(out_valid), 0);
    chk("err1_flag", 32'(route_error), 1);
    tick();
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    chk("err_sticky", 32'(route_error), 1);
    chk("err_no_valid", 32'(out_valid), 0);
    tick();

    // Reset mid-packet: input 2 -> output 2 (ptr[2] was left at 2).
    in_valid[2] = 1'b1;
    set_route(2, 4'b0100);
    tick();
    @(negedge clk);
    chk("rm_sel", sel(2), 2);
    chk("rm_f1_valid", 32'(out_valid), 32'h4);
    tick();
    @(negedge clk);
    chk("rm_f2_valid", 32'(out_valid), 32'h4);
    #2;
    rstnn = 1'b0;
    clear_inputs();
    #1;
    chk("rm_async_valid", 32'(out_valid), 0);
    chk("rm_async_ready", 32'(in_ready), 0);
    chk("rm_async_sel", 32'(out_sel), 0);
    chk("rm_async_err", 32'(route_error), 0);
    tick();
    tick();
    rstnn = 1'b1;
    in_valid = 4'b1010;
    in_last  = 4'b1010;
    set_route(1, 4'b0100);
    set_route(3, 4'b0100);
    @(negedge clk);
    chk("rm_rel_idle", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("rm_rel_sel", sel(2), 1);
    chk("rm_rel_ready", 32'(in_ready), 32'h2);
    chk("rm_rel_valid", 32'(out_valid), 32'h4);
    tick();
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
